key_conditioner: RTL and testbench

- Input stage directly upstream of the two-button code-lock FSM.
- Takes two raw, asynchronous, bouncing push-button signals.
- Synchronises and debounces each one, then turns each debounced press into a single-cycle pulse on b0/b1 that the lock consumes.
- Arbitrates between the keys so b0 and b1 are never high together, and flags chorded or simultaneous presses.

---
 rtl/lock_pkg.sv | 19 +
 rtl/key_debounce_chan.sv | 88 ++++++++
 rtl/key_conditioner.sv | 66 ++++++
 tb/tb_key_conditioner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the code-lock key input path.
// Holds the debounce FSM state encoding and the default timing constants.
// No ports; imported by key_debounce_chan and key_conditioner.
package lock_pkg;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int CW_DEF         = 5;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT = 2'd1;
  localparam logic [1:0] ST_HELD       = 2'd2;
  localparam logic [1:0] ST_REL_WAIT   = 2'd3;

  // Debounced level is 1 in HELD and REL_WAIT; the encoding puts that in bit 1.
  function automatic logic st_level(input logic [1:0] st);
    return (st == ST_HELD) || (st == ST_REL_WAIT);
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM and saturating-free counter.
// Ports: clk, rst (async active-low), key_raw in; level (registered), rise_evt
// (combinational, high during the cycle whose rising edge enters HELD from PRESS_WAIT).
module key_debounce_chan
  import lock_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic level,
  output logic rise_evt
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = key_raw;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rise_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync2_q) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = ST_HELD;
          cnt_d    = '0;
          rise_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!sync2_q) begin
          state_d = ST_REL_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_REL_WAIT: begin
        // A bounce back to 1 returns to HELD without a new rise event.
        if (sync2_q) begin
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Derived straight from the state flop, so it changes on the same edge as the state.
  assign level = st_level(state_q);

endmodule

// File: rtl/key_conditioner.sv
// Two-key front end for the code lock: debounce both keys, emit one-cycle press
// pulses b0/b1 (never together), and pulse conflict on simultaneous or chorded presses.
// Ports: clk, rst (async active-low), key0_raw/key1_raw in; b0, b1, k0_level, k1_level, conflict out.
module key_conditioner
  import lock_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key0_raw,
  input  logic key1_raw,
  output logic b0,
  output logic b1,
  output logic k0_level,
  output logic k1_level,
  output logic conflict
);

  logic rise0, rise1;
  logic b0_q, b0_d;
  logic b1_q, b1_d;
  logic conflict_q, conflict_d;

  key_debounce_chan #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_chan0 (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key0_raw),
    .level    (k0_level),
    .rise_evt (rise0)
  );

  key_debounce_chan #(.DEB_CYCLES(DEB_CYCLES), .CW(CW)) u_chan1 (
    .clk      (clk),
    .rst      (rst),
    .key_raw  (key1_raw),
    .level    (k1_level),
    .rise_evt (rise1)
  );

  // A rise is only forwarded when the other key is not debounced-down and not
  // rising on the same edge; otherwise the press is swallowed and flagged.
  always_comb begin
    b0_d       = rise0 && !rise1 && !k1_level;
    b1_d       = rise1 && !rise0 && !k0_level;
    conflict_d = (rise0 && rise1) || (rise0 && k1_level) || (rise1 && k0_level);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b0_q       <= 1'b0;
      b1_q       <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      conflict_q <= conflict_d;
    end
  end

  assign b0       = b0_q;
  assign b1       = b1_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner with DEB_CYCLES=4, CW=3.
// Expected pulses are queued with their edge number when a key is driven and
// popped as b0/b1/conflict pulses are observed.
module tb_key_conditioner;

  logic clk, rst, key0_raw, key1_raw;
  logic b0, b1, k0_level, k1_level, conflict;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         cyc;
    logic [2:0] v;   // {b0, b1, conflict}
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  key_conditioner #(.DEB_CYCLES(4), .CW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .key0_raw (key0_raw),
    .key1_raw (key1_raw),
    .b0       (b0),
    .b1       (b1),
    .k0_level (k0_level),
    .k1_level (k1_level),
    .conflict (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: after rising edge N, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and score any pulse seen there.
  task automatic step();
    @(negedge clk);
    if (rst && (b0 || b1 || conflict)) begin
      check("one_hot", {31'b0, b0 & b1}, 32'd0);
      if (sb_q.size() == 0) begin
        check("spurious", {29'b0, b0, b1, conflict}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_edge", cyc, mon_e.cyc);
        check("pulse_kind", {29'b0, b0, b1, conflict}, {29'b0, mon_e.v});
      end
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic at_edge(input int e);
    while (cyc < e) step();
  endtask

  task automatic expect_pulse(input int e, input logic [2:0] v);
    exp_t x;
    x.cyc = e;
    x.v   = v;
    sb_q.push_back(x);
  endtask

  task automatic check_drained(input string tag);
    check(tag, sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  int c, r;
  logic [6:0] bounce_pat;
  logic [4:0] code_seq;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; key0_raw = 1'b0; key1_raw = 1'b0;
    #1;
    check("rst_out", {27'b0, b0, b1, k0_level, k1_level, conflict}, 32'd0);
    tick(3);
    rst = 1'b1;
    tick(2);

    // 1. Reset mid-debounce, then release with key held.
    c = cyc;
    key0_raw = 1'b1;
    at_edge(c + 4);
    check("pw_level", {31'b0, k0_level}, 32'd0);
    #1 rst = 1'b0;
    #1 check("rst_pw_out", {27'b0, b0, b1, k0_level, k1_level, conflict}, 32'd0);
    tick(2);
    #1 rst = 1'b1;
    c = cyc;
    expect_pulse(c + 6, 3'b100);
    at_edge(c + 5);
    check("rel_lvl_pre", {31'b0, k0_level}, 32'd0);
    at_edge(c + 6);
    check("rel_lvl_post", {31'b0, k0_level}, 32'd1);
    key0_raw = 1'b0;
    tick(8);
    // Reset mid-pulse: b0 and k0_level high, both must clear before the next edge.
    c = cyc;
    key0_raw = 1'b1;
    expect_pulse(c + 6, 3'b100);
    at_edge(c + 6);
    #1 rst = 1'b0;
    #1 check("rst_pulse_out", {27'b0, b0, b1, k0_level, k1_level, conflict}, 32'd0);
    key0_raw = 1'b0;
    tick(2);
    #1 rst = 1'b1;
    tick(10);
    check_drained("s1_drained");

    // 2. Clean press of 12 cycles.
    c = cyc;
    key0_raw = 1'b1;
    expect_pulse(c + 6, 3'b100);
    at_edge(c + 5);
    check("s2_lvl_pre", {31'b0, k0_level}, 32'd0);
    at_edge(c + 6);
    check("s2_lvl_up", {31'b0, k0_level}, 32'd1);
    at_edge(c + 12);
    key0_raw = 1'b0;
    r = cyc;
    at_edge(r + 5);
    check("s2_lvl_hold", {31'b0, k0_level}, 32'd1);
    at_edge(r + 6);
    check("s2_lvl_down", {31'b0, k0_level}, 32'd0);
    tick(6);
    check_drained("s2_drained");

    // 3. Bounce on key1, then a short glitch while held.
    bounce_pat = 7'b1001011;  // sent LSB first: 1,1,0,1,0,0,1
    for (int i = 0; i < 7; i++) begin
      key1_raw = bounce_pat[i];
      c = cyc;
      step();
    end
    expect_pulse(c + 6, 3'b010);
    at_edge(c + 10);
    check("s3_lvl", {31'b0, k1_level}, 32'd1);
    key1_raw = 1'b0;
    tick(2);
    key1_raw = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("s3_glitch_lvl", {31'b0, k1_level}, 32'd1);
    end
    key1_raw = 1'b0;
    tick(10);
    check("s3_lvl_off", {31'b0, k1_level}, 32'd0);
    check_drained("s3_drained");

    // 4. Simultaneous press.
    c = cyc;
    key0_raw = 1'b1; key1_raw = 1'b1;
    expect_pulse(c + 6, 3'b001);
    at_edge(c + 5);
    check("s4_lvls_pre", {30'b0, k0_level, k1_level}, 32'd0);
    at_edge(c + 6);
    check("s4_lvls_post", {30'b0, k0_level, k1_level}, 32'd3);
    tick(3);
    key0_raw = 1'b0; key1_raw = 1'b0;
    tick(10);
    check_drained("s4_drained");

    // 5. Chord: key1 held, then key0 pressed; then key0 alone.
    c = cyc;
    key1_raw = 1'b1;
    expect_pulse(c + 6, 3'b010);
    at_edge(c + 8);
    c = cyc;
    key0_raw = 1'b1;
    expect_pulse(c + 6, 3'b001);
    at_edge(c + 6);
    check("s5_lvls", {30'b0, k0_level, k1_level}, 32'd3);
    tick(3);
    key0_raw = 1'b0; key1_raw = 1'b0;
    tick(10);
    c = cyc;
    key0_raw = 1'b1;
    expect_pulse(c + 6, 3'b100);
    at_edge(c + 9);
    key0_raw = 1'b0;
    tick(10);
    check_drained("s5_drained");

    // 6. Code sequence 0,1,0,1,1.
    code_seq = 5'b11010;  // LSB first: 0,1,0,1,1
    for (int i = 0; i < 5; i++) begin
      c = cyc;
      if (code_seq[i]) key1_raw = 1'b1;
      else             key0_raw = 1'b1;
      expect_pulse(c + 6, code_seq[i] ? 3'b010 : 3'b100);
      tick(8);
      key0_raw = 1'b0; key1_raw = 1'b0;
      tick(8);
    end
    tick(4);
    check_drained("s6_drained");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
